aes128_enc_iter: RTL and testbench

Iterative AES-128 encryption datapath that consumes the 1408-bit packed round-key bus produced by the combinational key expansion stage and encrypts one 128-bit block in one round per clock. It sits directly downstream of key expansion and upstream of the GCM counter-mode/GHASH logic. Blocks move in and out over valid/ready handshakes.

---
 rtl/aes128_enc_iter.sv | 132 +++++++++++++
 tb/tb_aes128_enc_iter.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/aes128_enc_iter.sv
// Iterative AES-128 encryptor: one round per clock over a 128-bit state register,
// round keys taken combinationally from the expanded 1408-bit key bus.

module aes128_sbox (
    input  logic [7:0] a_i,
    output logic [7:0] y_o
);
    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    assign y_o = SBOX[a_i];
endmodule

module aes128_mixcol (
    input  logic [31:0] col_i,
    output logic [31:0] col_o
);
    function automatic logic [7:0] xt(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    logic [7:0] a0, a1, a2, a3;
    assign {a0, a1, a2, a3} = col_i;

    // Fixed matrix {02 03 01 01} rotated per row; 3*x = xt(x) ^ x.
    assign col_o = {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
                    a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
                    a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
                    xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
endmodule

module aes128_enc_iter (
    input  logic          clk,
    input  logic          rst,
    input  logic [1407:0] round_keys,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [127:0]  block_in,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [127:0]  block_out,
    output logic          busy
);
    typedef enum logic [1:0] {IDLE, ROUND, DONE} fsm_e;

    fsm_e         fsm_q, fsm_d;
    logic [3:0]   round_q, round_d;
    logic [127:0] state_q, state_d;

    // Padded to 16 entries so a 4-bit round index never leaves the array.
    logic [0:15][127:0] rk_arr;
    logic [127:0]       rk_sel;
    assign rk_arr = {round_keys, {5{128'h0}}};
    assign rk_sel = rk_arr[round_q];

    logic [0:15][7:0] sb, sr;
    logic [127:0]     mc, round_out;

    for (genvar b = 0; b < 16; b++) begin : g_sub
        aes128_sbox u_sbox (.a_i(state_q[127-8*b -: 8]), .y_o(sb[b]));
    end

    for (genvar c = 0; c < 4; c++) begin : g_col
        for (genvar r = 0; r < 4; r++) begin : g_row
            assign sr[4*c+r] = sb[4*((c+r)%4)+r];
        end
        aes128_mixcol u_mix (
            .col_i({sr[4*c], sr[4*c+1], sr[4*c+2], sr[4*c+3]}),
            .col_o(mc[127-32*c -: 32])
        );
    end

    // Final round skips MixColumns.
    assign round_out = ((round_q == 4'd10) ? sr : mc) ^ rk_sel;

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q   <= IDLE;
            round_q <= 4'd0;
            state_q <= 128'h0;
        end else begin
            fsm_q   <= fsm_d;
            round_q <= round_d;
            state_q <= state_d;
        end
    end

    always_comb begin
        fsm_d   = fsm_q;
        round_d = round_q;
        state_d = state_q;
        unique case (fsm_q)
            IDLE: begin
                if (in_valid) begin
                    state_d = block_in ^ round_keys[1407:1280];
                    round_d = 4'd1;
                    fsm_d   = ROUND;
                end
            end
            ROUND: begin
                state_d = round_out;
                if (round_q == 4'd10) fsm_d = DONE;
                else                  round_d = round_q + 4'd1;
            end
            DONE: begin
                if (out_ready) fsm_d = IDLE;
            end
            default: fsm_d = IDLE;
        endcase
    end

    assign in_ready  = (fsm_q == IDLE) && !rst;
    assign out_valid = (fsm_q == DONE);
    assign busy      = (fsm_q == ROUND) || (fsm_q == DONE);
    assign block_out = state_q;
endmodule

// File: tb/tb_aes128_enc_iter.sv
// Directed bench for aes128_enc_iter using FIPS-197 and SP800-38A ECB vectors.
module tb_aes128_enc_iter;
    logic          clk = 1'b0;
    logic          rst, in_valid, out_ready;
    logic [1407:0] round_keys;
    logic [127:0]  block_in;
    logic          in_ready, out_valid, busy;
    logic [127:0]  block_out;

    aes128_enc_iter dut (
        .clk(clk), .rst(rst), .round_keys(round_keys),
        .in_valid(in_valid), .in_ready(in_ready), .block_in(block_in),
        .out_valid(out_valid), .out_ready(out_ready), .block_out(block_out),
        .busy(busy)
    );

    always #5 clk = ~clk;

    localparam logic [0:255][7:0] SB = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int           accq[$];
    logic [127:0] outq[$];
    logic [1407:0] rk_b, rk_c;
    logic [127:0]  b2b_pt[4];
    logic [127:0]  b2b_ct[4];
    logic          flag, flag2;

    function automatic logic [1407:0] key_expand(input logic [127:0] key);
        logic [31:0]   w[44];
        logic [31:0]   t;
        logic [7:0]    rc;
        logic [1407:0] r;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {SB[t[31:24]], SB[t[23:16]], SB[t[15:8]], SB[t[7:0]]} ^ {rc, 24'h0};
                rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int i = 0; i < 44; i++) r[1407-32*i -: 32] = w[i];
        return r;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: records accepts and output handshakes seen at the edge.
    task automatic tick();
        logic         acc, hs;
        logic [127:0] bo;
        #1;
        acc = in_valid && in_ready;
        hs  = out_valid && out_ready;
        bo  = block_out;
        @(posedge clk);
        cyc++;
        if (acc) accq.push_back(cyc);
        if (hs)  outq.push_back(bo);
        #1;
    endtask

    initial begin
        rk_b = key_expand(KEY_B);
        rk_c = key_expand(KEY_C);
        b2b_pt = '{128'h6bc1bee22e409f96e93d7e117393172a, 128'hae2d8a571e03ac9c9eb76fac45af8e51,
                   128'h30c81c46a35ce411e5fbc1191a0a52ef, 128'hf69f2445df4f9b17ad2b417be66c3710};
        b2b_ct = '{128'h3ad77bb40d7a3660a89ecaf32466ef97, 128'hf5d3d58503b9699de785895a96fdbaaf,
                   128'h43b1cd7f598ece23881b00e3ed030688, 128'h7b0c785e27e8ad3f8223207104725dd4};

        // Reset
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; block_in = '0; round_keys = '0;
        tick(); tick();
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_block_out", block_out, 0);
        rst = 1'b0; #1;
        chk("rst_release_in_ready", in_ready, 1);

        // FIPS-197 Appendix B: latency and busy
        accq.delete(); outq.delete();
        round_keys = rk_b; block_in = PT_B; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        flag = 1'b0; flag2 = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (i < 10 && out_valid) flag = 1'b1;
            flag2 = flag2 & busy;
        end
        chk("B_early_out_valid", flag, 0);
        chk("B_busy_all_rounds", flag2, 1);
        chk("B_out_valid_at_E10", out_valid, 1);
        chk("B_block_out", block_out, CT_B);
        tick();
        chk("B_hs_count", outq.size(), 1);
        chk("B_hs_value", (outq.size() > 0) ? outq[0] : 'x, CT_B);
        chk("B_idle_after_hs", {in_ready, out_valid, busy}, 3'b100);

        // C.1 with 20 cycles of back-pressure
        accq.delete(); outq.delete();
        round_keys = rk_c; block_in = PT_C; in_valid = 1'b1; out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 20 && !out_valid; i++) tick();
        chk("C1_out_valid", out_valid, 1);
        chk("C1_block_out", block_out, CT_C);
        flag = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (!(out_valid === 1'b1 && block_out === CT_C && in_ready === 1'b0)) flag = 1'b0;
        end
        chk("bp_stable_20", flag, 1);
        out_ready = 1'b1;
        tick();
        chk("bp_idle_after_hs", {in_ready, out_valid, busy}, 3'b100);
        chk("bp_hs_value", (outq.size() == 1) ? outq[0] : 'x, CT_C);

        // in_valid held high while busy with a different block
        accq.delete(); outq.delete();
        round_keys = rk_b; block_in = PT_B; in_valid = 1'b1;
        tick();
        block_in = b2b_pt[0];
        flag = 1'b1;
        for (int i = 0; i < 40 && accq.size() < 2; i++) begin
            tick();
            if (accq.size() < 2 && busy && in_ready !== 1'b0) flag = 1'b0;
        end
        in_valid = 1'b0;
        chk("busy_in_ready_low", flag, 1);
        chk("busy_accepts", accq.size(), 2);
        chk("busy_spacing", (accq.size() == 2) ? accq[1] - accq[0] : -1, 12);
        for (int i = 0; i < 30 && outq.size() < 2; i++) tick();
        chk("busy_ct0", (outq.size() > 0) ? outq[0] : 'x, CT_B);
        chk("busy_ct1", (outq.size() > 1) ? outq[1] : 'x, b2b_ct[0]);

        // Reset in round 5
        accq.delete(); outq.delete();
        round_keys = rk_c; block_in = PT_C; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        rst = 1'b1; #1;
        chk("midrst_in_ready_forced", in_ready, 0);
        tick();
        rst = 1'b0;
        chk("midrst_outs", {out_valid, busy, block_out}, 130'h0);
        #1;
        chk("midrst_in_ready", in_ready, 1);
        flag = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (out_valid !== 1'b0) flag = 1'b1;
        end
        chk("midrst_no_out_valid", flag, 0);
        block_in = PT_C; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 20 && outq.size() < 1; i++) tick();
        chk("midrst_next_ct", (outq.size() > 0) ? outq[0] : 'x, CT_C);

        // Back-to-back
        accq.delete(); outq.delete();
        round_keys = rk_b; out_ready = 1'b1; in_valid = 1'b1; block_in = b2b_pt[0];
        for (int i = 0; i < 80 && outq.size() < 4; i++) begin
            tick();
            if (accq.size() < 4) block_in = b2b_pt[accq.size()];
            else                 in_valid = 1'b0;
        end
        in_valid = 1'b0;
        chk("b2b_count", outq.size(), 4);
        for (int i = 0; i < 4; i++)
            chk($sformatf("b2b_ct%0d", i), (i < outq.size()) ? outq[i] : 'x, b2b_ct[i]);
        for (int i = 1; i < 4; i++)
            chk($sformatf("b2b_spacing%0d", i), (i < accq.size()) ? accq[i] - accq[i-1] : -1, 12);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
